// File: rtl/mtl1_bus_pkg.sv
// mtl1_bus_pkg: shared definitions for the MTL-1 6809 bus front-end.
//   bus_state_t       bridge FSM states (IDLE/SETUP/REQ/HOLD)
//   MTL1_REGION_BASE  default flattened region base addresses (slice k = region k)
//   MTL1_REGION_MASK  default flattened region compare masks
//   ERR_DATA_FILL     all-ones read data returned on a bus timeout
package mtl1_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    HOLD  = 2'd3
  } bus_state_t;

  // Region 0: 0x0xxx, region 1: 0x1xxx, region 2: 0xA000-0xA003, region 3: 0xFxxx
  localparam logic [63:0] MTL1_REGION_BASE = {16'hF000, 16'hA000, 16'h1000, 16'h0000};
  localparam logic [63:0] MTL1_REGION_MASK = {16'hF000, 16'hFFFC, 16'hF000, 16'hF000};

  localparam logic [63:0] ERR_DATA_FILL = '1;

endpackage

// File: rtl/bus_sync_edge.sv
// bus_sync_edge: two-flop synchroniser for an asynchronous 6809 pin plus a
// third flop for edge detection.
// Ports:
//   clk, reset  internal clock, synchronous active-high reset
//   d           asynchronous input pin
//   level       synchronised level (second flop)
//   rise, fall  one-cycle pulses on synchronised rising/falling edge
module bus_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: 6809 bus front-end for the MTL-1 adapter.
// Synchronises E/RW, decodes the address against N_REGIONS windows, runs a
// req/ack handshake with the selected peripheral, stretches the CPU through
// MRDY while it waits, and holds read data on the bus until E falls.
// Optional feature macro: BUS_TIMEOUT_EN (REQ wait limit with o_err pulse).
// Ports:
//   clk, reset        internal oscillator clock, synchronous active-high reset
//   i_E, i_RW         asynchronous 6809 E and R/W (1 = read)
//   i_ADDRESS, i_DATA 6809 address and data bus input
//   o_DATA, o_DATA_OE data bus drive value and tri-state enable
//   o_MRDY            0 stretches E/Q
//   o_sel, o_rd, o_wr one-hot peripheral select and request qualifiers
//   o_wdata           write data to peripheral
//   i_rdata, i_ack    flattened peripheral read data, per-peripheral done
//   o_err             one-cycle timeout pulse (0 without BUS_TIMEOUT_EN)
module cpu_bus_bridge
  import mtl1_bus_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned N_REGIONS       = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = (N_REGIONS*ADDR_W)'(MTL1_REGION_BASE),
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = (N_REGIONS*ADDR_W)'(MTL1_REGION_MASK),
  parameter int unsigned WR_SETUP_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_E,
  input  logic                        i_RW,
  input  logic [ADDR_W-1:0]           i_ADDRESS,
  input  logic [DATA_W-1:0]           i_DATA,
  output logic [DATA_W-1:0]           o_DATA,
  output logic                        o_DATA_OE,
  output logic                        o_MRDY,
  output logic [N_REGIONS-1:0]        o_sel,
  output logic                        o_rd,
  output logic                        o_wr,
  output logic [DATA_W-1:0]           o_wdata,
  input  logic [N_REGIONS*DATA_W-1:0] i_rdata,
  input  logic [N_REGIONS-1:0]        i_ack,
  output logic                        o_err
);

  localparam int unsigned IDX_W    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam logic [4:0]  WR_SETUP = 5'(WR_SETUP_CYCLES);

  bus_state_t state, state_nx;

  logic             rise_e, fall_e, rw_s;
  logic             unused_e_level, unused_rw_rise, unused_rw_fall;
  logic             hit;
  logic [IDX_W-1:0] hit_idx, idx_q;
  logic             rw_q;
  logic [3:0]       setup_cnt;
  logic             setup_done;
  logic [N_REGIONS-1:0] sel_onehot;
  logic             ack_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic             timeout;

  bus_sync_edge u_sync_e (
    .clk   (clk),
    .reset (reset),
    .d     (i_E),
    .level (unused_e_level),
    .rise  (rise_e),
    .fall  (fall_e)
  );

  // RW is only needed as a level.
  bus_sync_edge u_sync_rw (
    .clk   (clk),
    .reset (reset),
    .d     (i_RW),
    .level (rw_s),
    .rise  (unused_rw_rise),
    .fall  (unused_rw_fall)
  );

  // Address decode; the first matching window (lowest index) wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < N_REGIONS; k++) begin
      if (!hit && ((i_ADDRESS & REGION_MASK[k*ADDR_W +: ADDR_W]) ==
                   REGION_BASE[k*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Everything peripheral-facing is steered by the latched region index, so
  // acks and read data from unselected peripherals never reach the FSM.
  always_comb begin
    sel_onehot = '0;
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    for (int unsigned k = 0; k < N_REGIONS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_onehot[k] = 1'b1;
        ack_sel       = i_ack[k];
        rdata_sel     = i_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Reads leave SETUP after one cycle; writes after WR_SETUP_CYCLES (min 1).
  assign setup_done = rw_q | (({1'b0, setup_cnt} + 5'd1) >= WR_SETUP);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // to_cnt holds the zero-based REQ cycle number.
  assign timeout = (state == REQ) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      o_err  <= 1'b0;
    end else begin
      o_err <= timeout && !ack_sel && !fall_e;
      if (state == REQ) to_cnt <= to_cnt + TO_W'(1);
      else              to_cnt <= '0;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    o_sel     = '0;
    o_rd      = 1'b0;
    o_wr      = 1'b0;
    o_MRDY    = 1'b1;
    o_DATA_OE = 1'b0;
    case (state)
      IDLE: begin
        if (rise_e && hit) state_nx = SETUP;
      end
      SETUP: begin
        o_MRDY = 1'b0;
        if (fall_e)          state_nx = IDLE;
        else if (setup_done) state_nx = REQ;
      end
      REQ: begin
        o_MRDY = 1'b0;
        o_sel  = sel_onehot;
        o_rd   = rw_q;
        o_wr   = ~rw_q;
        if (fall_e)                  state_nx = IDLE;
        else if (ack_sel || timeout) state_nx = HOLD;
      end
      HOLD: begin
        o_DATA_OE = rw_q;
        if (fall_e) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      rw_q      <= 1'b0;
      setup_cnt <= '0;
      o_wdata   <= '0;
      o_DATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_e && hit) begin
            idx_q     <= hit_idx;
            rw_q      <= rw_s;
            setup_cnt <= '0;
          end
        end
        SETUP: begin
          setup_cnt <= setup_cnt + 4'd1;
          if (!fall_e && setup_done && !rw_q) o_wdata <= i_DATA;
        end
        REQ: begin
          // An ack on the timeout cycle takes precedence over the error fill.
          if (!fall_e) begin
            if (ack_sel) begin
              if (rw_q) o_DATA <= rdata_sel;
            end else if (timeout) begin
              o_DATA <= ERR_DATA_FILL[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
module tb_cpu_bus_bridge;

  localparam int unsigned WR_SETUP = 4;
  localparam int unsigned TO_CYC   = 8;

  localparam logic [15:0] BASE_TAB [4] = '{16'h0000, 16'h1000, 16'hA000, 16'hF000};
  localparam logic [15:0] MASK_TAB [4] = '{16'hF000, 16'hF000, 16'hFFFC, 16'hF000};

  logic        clk = 1'b0;
  logic        reset;
  logic        i_E, i_RW;
  logic [15:0] i_ADDRESS;
  logic [7:0]  i_DATA;
  logic [7:0]  o_DATA;
  logic        o_DATA_OE, o_MRDY, o_rd, o_wr, o_err;
  logic [3:0]  o_sel;
  logic [7:0]  o_wdata;
  logic [31:0] i_rdata;
  logic [3:0]  i_ack;

  logic [3:0]  ovl_sel;
  logic        ovl_rd, ovl_wr;
  logic [7:0]  unused_ovl_data, unused_ovl_wdata;
  logic        unused_ovl_oe, unused_ovl_mrdy, unused_ovl_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cpu_bus_bridge #(
    .ADDR_W          (16),
    .DATA_W          (8),
    .N_REGIONS       (4),
    .WR_SETUP_CYCLES (WR_SETUP),
    .TIMEOUT_CYCLES  (TO_CYC)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .i_E       (i_E),
    .i_RW      (i_RW),
    .i_ADDRESS (i_ADDRESS),
    .i_DATA    (i_DATA),
    .o_DATA    (o_DATA),
    .o_DATA_OE (o_DATA_OE),
    .o_MRDY    (o_MRDY),
    .o_sel     (o_sel),
    .o_rd      (o_rd),
    .o_wr      (o_wr),
    .o_wdata   (o_wdata),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .o_err     (o_err)
  );

  // Every window overlaps everything: region 0 must always be chosen.
  // Its peripheral acknowledges in the first REQ cycle.
  cpu_bus_bridge #(
    .ADDR_W          (16),
    .DATA_W          (8),
    .N_REGIONS       (4),
    .REGION_BASE     (64'h0),
    .REGION_MASK     (64'h0),
    .WR_SETUP_CYCLES (WR_SETUP),
    .TIMEOUT_CYCLES  (TO_CYC)
  ) u_ovl (
    .clk       (clk),
    .reset     (reset),
    .i_E       (i_E),
    .i_RW      (i_RW),
    .i_ADDRESS (i_ADDRESS),
    .i_DATA    (i_DATA),
    .o_DATA    (unused_ovl_data),
    .o_DATA_OE (unused_ovl_oe),
    .o_MRDY    (unused_ovl_mrdy),
    .o_sel     (ovl_sel),
    .o_rd      (ovl_rd),
    .o_wr      (ovl_wr),
    .o_wdata   (unused_ovl_wdata),
    .i_rdata   (i_rdata),
    .i_ack     (ovl_sel),
    .o_err     (unused_ovl_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: first window whose masked compare matches, else -1.
  function automatic int model_region(input logic [15:0] a);
    for (int k = 0; k < 4; k++)
      if ((a & MASK_TAB[k]) == BASE_TAB[k]) return k;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   o_sel, 0);
    check({tag, "_rd"},    o_rd, 0);
    check({tag, "_wr"},    o_wr, 0);
    check({tag, "_wdata"}, o_wdata, 0);
    check({tag, "_data"},  o_DATA, 0);
    check({tag, "_oe"},    o_DATA_OE, 0);
    check({tag, "_mrdy"},  o_MRDY, 1);
    check({tag, "_err"},   o_err, 0);
  endtask

  // One complete E cycle. Inputs change one time unit after a clock edge;
  // E is seen as risen two edges later and SETUP starts on the third.
  task automatic do_txn(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                        input logic [31:0] rd_all, input int unsigned ack_dly,
                        input int unsigned hold_n);
    int          reg_k;
    int unsigned setup_len;
    logic [3:0]  onehot;
    logic [7:0]  exp_rd;
    reg_k     = model_region(addr);
    i_ADDRESS = addr;
    i_RW      = rw;
    i_DATA    = wd;
    i_rdata   = rd_all;
    i_ack     = '0;
    i_E       = 1'b1;
    tick(); check("sync1_mrdy", o_MRDY, 1);
    tick(); check("sync2_sel", o_sel, 0);
    if (reg_k < 0) begin
      repeat (6) begin
        tick();
        check("nohit_sel", o_sel, 0);
        check("nohit_mrdy", o_MRDY, 1);
        check("nohit_oe", o_DATA_OE, 0);
      end
      i_E = 1'b0;
      repeat (3) tick();
      check("nohit_end_oe", o_DATA_OE, 0);
      return;
    end
    onehot    = 4'b0001 << reg_k;
    setup_len = rw ? 1 : ((WR_SETUP == 0) ? 1 : WR_SETUP);
    for (int unsigned s = 0; s < setup_len; s++) begin
      tick();
      check("setup_mrdy", o_MRDY, 0);
      check("setup_sel", o_sel, 0);
    end
    for (int unsigned j = 0; j <= ack_dly; j++) begin
      tick();
      check("req_sel", o_sel, onehot);
      check("req_rd", o_rd, rw);
      check("req_wr", o_wr, !rw);
      check("req_mrdy", o_MRDY, 0);
      check("req_oe", o_DATA_OE, 0);
      if (j == 0) begin
        check("ovl_sel", ovl_sel, 4'b0001);
        check("ovl_rd", ovl_rd, rw);
        if (!rw) check("req_wdata", o_wdata, wd);
      end
      // Stray acks from other regions must not end the request.
      i_ack = (j == ack_dly) ? onehot : (4'($urandom) & ~onehot);
    end
    tick();
    i_ack  = '0;
    exp_rd = rd_all[reg_k*8 +: 8];
    check("hold_sel", o_sel, 0);
    check("hold_mrdy", o_MRDY, 1);
    check("hold_oe", o_DATA_OE, rw);
    if (rw) check("hold_data", o_DATA, exp_rd);
    repeat (hold_n) begin
      tick();
      check("hold_oe_keep", o_DATA_OE, rw);
    end
    i_E = 1'b0;
    tick(); check("fall_s1_oe", o_DATA_OE, rw);
    tick(); check("fall_edge_oe", o_DATA_OE, rw);
    tick();
    check("after_fall_oe", o_DATA_OE, 0);
    check("after_fall_mrdy", o_MRDY, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic        rw;
    int unsigned pick;

    reset = 1'b1; i_E = 1'b0; i_RW = 1'b1; i_ADDRESS = '0; i_DATA = '0;
    i_rdata = '0; i_ack = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) tick();

    // Directed: read region 0, write region 2, unmapped address.
    do_txn(16'h0123, 1'b1, 8'h00, 32'h1122_335A, 3, 2);
    do_txn(16'hA001, 1'b0, 8'hC3, 32'hDEAD_BEEF, 1, 1);
    do_txn(16'h9000, 1'b1, 8'h00, 32'h0, 0, 0);

    // E falls while the request is still outstanding: abort, nothing driven.
    i_ADDRESS = 16'h1FFF; i_RW = 1'b1; i_ack = '0; i_E = 1'b1;
    repeat (5) tick();
    check("abort_req_sel", o_sel, 4'b0010);
    i_E = 1'b0;
    tick(); tick();
    check("abort_pre_sel", o_sel, 4'b0010);
    tick();
    check("abort_sel", o_sel, 0);
    check("abort_mrdy", o_MRDY, 1);
    check("abort_oe", o_DATA_OE, 0);
    repeat (2) tick();

    // Peripheral never acknowledges.
    i_ADDRESS = 16'h1234; i_RW = 1'b1; i_rdata = 32'h0; i_ack = '0; i_E = 1'b1;
    repeat (3) tick();
`ifdef BUS_TIMEOUT_EN
    for (int unsigned j = 1; j <= TO_CYC; j++) begin
      tick();
      check("to_wait_mrdy", o_MRDY, 0);
      check("to_wait_err", o_err, 0);
      check("to_wait_sel", o_sel, 4'b0010);
    end
    tick();
    check("to_err", o_err, 1);
    check("to_data", o_DATA, 8'hFF);
    check("to_mrdy", o_MRDY, 1);
    check("to_oe", o_DATA_OE, 1);
    check("to_sel", o_sel, 0);
    tick();
    check("to_err_pulse", o_err, 0);
`else
    for (int unsigned j = 1; j <= 3 * TO_CYC; j++) begin
      tick();
      check("nto_mrdy", o_MRDY, 0);
      check("nto_err", o_err, 0);
    end
    i_ack = 4'b0010;
    tick();
    i_ack = '0;
    check("nto_ack_mrdy", o_MRDY, 1);
`endif
    i_E = 1'b0;
    repeat (3) tick();
    check("to_end_oe", o_DATA_OE, 0);

    // Reset while in REQ.
    i_ADDRESS = 16'h0123; i_RW = 1'b1; i_ack = '0; i_E = 1'b1;
    repeat (4) tick();
    check("rst_req_sel", o_sel, 4'b0001);
    reset = 1'b1;
    i_E   = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    repeat (2) tick();
    do_txn(16'h0ABC, 1'b1, 8'h00, 32'h0000_00A7, 0, 1);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: a = {4'h0, 12'($urandom)};
        1: a = {4'h1, 12'($urandom)};
        2: a = 16'hA000 | 16'($urandom_range(0, 3));
        3: a = {4'hF, 12'($urandom)};
        default: a = 16'($urandom);
      endcase
      rw = 1'($urandom);
      do_txn(a, rw, 8'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Parametrised 6809 bus front-end for the MTL-1 adapter. It replaces the fixed per-peripheral tri-state data muxing and the combinational MRDY handling.
- Synchronises i_E/i_RW into the internal oscillator domain and decodes the address against N_REGIONS programmable windows.
- Runs a req/ack handshake to exactly one peripheral, stretches the CPU via o_MRDY while the peripheral is busy, and holds read data on the bus until E falls.
- Sits between the 6809 pins and the SRAM/SPI-flash/UART controllers.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- N_REGIONS, 4, number of decoded peripheral windows.
- REGION_BASE, {16'hF000,16'hA000,16'h1000,16'h0000}, flattened N_REGIONS*ADDR_W base addresses; slice k is region k.
- REGION_MASK, {16'hF000,16'hFFFC,16'hF000,16'hF000}, flattened compare masks. Hit k when (addr & mask_k) == base_k.
- WR_SETUP_CYCLES, 4, clk cycles from the detected E rise to sampling write data (0..15).
- TIMEOUT_CYCLES, 255, wait limit; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  internal oscillator clock
- reset  in  1  synchronous, active-high
- i_E  in  1  6809 E, asynchronous
- i_RW  in  1  6809 R/W (1 = read), asynchronous
- i_ADDRESS  in  ADDR_W  6809 address
- i_DATA  in  DATA_W  data bus input
- o_DATA  out  DATA_W  data bus drive value
- o_DATA_OE  out  1  data bus drive enable (top-level tri-state)
- o_MRDY  out  1  0 = stretch E/Q
- o_sel  out  N_REGIONS  one-hot peripheral select
- o_rd  out  1  read request qualifier
- o_wr  out  1  write request qualifier
- o_wdata  out  DATA_W  write data to peripheral
- i_rdata  in  N_REGIONS*DATA_W  flattened peripheral read data
- i_ack  in  N_REGIONS  peripheral done; slice k only honoured while o_sel[k]
- o_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (synchronous, every clk edge with reset=1):
  - state IDLE.
  - o_sel=0, o_rd=0, o_wr=0, o_wdata=0, o_DATA=0, o_DATA_OE=0, o_MRDY=1, o_err=0.
  - Synchroniser flops cleared.
  - A reset mid-transaction aborts it; nothing is driven next cycle.
- Synchronisation:
  - i_E and i_RW each pass through 2 flops. A third E flop gives the edges.
  - rise_e = s2 & ~s3; fall_e = ~s2 & s3.
- Decode:
  - Registered on the rise_e cycle, lowest index wins.
  - No hit: stay IDLE and drive nothing. o_MRDY stays 1.
- States: IDLE, SETUP, REQ, HOLD.
  - IDLE -> SETUP on rise_e with a hit. Latch the region index and synced RW.
  - SETUP:
    - Reads proceed to REQ after 1 cycle.
    - Writes count WR_SETUP_CYCLES, then sample i_DATA into o_wdata and go to REQ.
    - o_MRDY=0 from SETUP entry.
  - REQ:
    - o_sel[k]=1, with o_rd=RW or o_wr=~RW, all held until i_ack[k].
    - On the ack cycle: latch the i_rdata slice k into o_DATA (reads), then go to HOLD next cycle.
    - Ack in the first REQ cycle is legal, giving a minimum REQ of 1 cycle.
  - HOLD:
    - o_sel/o_rd/o_wr = 0, o_MRDY=1, o_DATA_OE = latched RW.
    - On fall_e: go to IDLE; o_DATA_OE falls in the same registered update.
- Other rules:
  - Stray i_ack bits for unselected regions are ignored.
  - rise_e while not IDLE is ignored.
  - If fall_e arrives in SETUP or REQ (not possible with MRDY low on a real 6809), abort to IDLE with no data driven.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If TIMEOUT_CYCLES elapse with no ack, force o_DATA to all-ones and pulse o_err for 1 cycle, then go to HOLD with o_MRDY=1.
  - An ack arriving on the same cycle as the timeout wins, and no error is flagged.
- Undefined:
  - No counter is built; REQ waits indefinitely.
  - o_err is tied to 0.

Decomposition:
- Package mtl1_bus_pkg holds:
  - state encoding localparams (IDLE=0, SETUP=1, REQ=2, HOLD=3);
  - default MTL-1 region base/mask constants;
  - the all-ones error data constant.
- One sub-module, bus_sync_edge: 2-flop synchroniser plus edge detector, instantiated for E (edges used) and RW (level only).

Test Plan:
- Read from region 0: E rise with addr=16'h0123, RW=1, ack after 3 cycles with rdata slice0=8'h5A.
  -> o_sel=4'b0001; o_MRDY=0 from SETUP until ack+1; o_DATA=8'h5A with OE=1 until the cycle after fall_e.
- Write to addr=16'hA001, data 8'hC3.
  -> o_sel[2]=1 exactly WR_SETUP_CYCLES+1 cycles after the detected rise; o_wdata=8'hC3; o_wr=1; OE never asserted.
- Unmapped addr=16'h9000.
  -> no sel, o_MRDY=1 throughout, OE=0.
- Overlap check: region bases 0x0000 and 0x0000/mask 0.
  -> index 0 selected.
- Reset asserted in REQ.
  -> next cycle every output at its reset value; a fresh read afterwards completes normally.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack.
  -> o_err pulse on REQ cycle 9, o_DATA=8'hFF, o_MRDY=1. Without the macro: MRDY stays 0 indefinitely.
